// File: rtl/axi2iob.sv
// AXI4 slave to native (IOb) master bridge: one burst at a time, each AXI beat
// replayed as a single native access; unsupported bursts answered with SLVERR.
module axi2iob #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_ID_W  = 1,
  parameter int AXI_LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // write address
  input  logic [AXI_ID_W-1:0]   s_awid,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic [AXI_LEN_W-1:0]  s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  // write data
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  // write response
  output logic [AXI_ID_W-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  // read address
  input  logic [AXI_ID_W-1:0]   s_arid,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic [AXI_LEN_W-1:0]  s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  // read data
  output logic [AXI_ID_W-1:0]   s_rid,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  // native master
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ready
);

  localparam int                STRB_W      = DATA_W / 8;
  localparam logic [2:0]        SIZE_OK     = 3'($clog2(STRB_W));
  localparam logic [ADDR_W-1:0] STEP        = ADDR_W'(STRB_W);
  localparam logic [1:0]        BURST_FIXED = 2'b00;
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [AXI_LEN_W-1:0]  cnt_q, cnt_d;
  logic                  fixed_q, fixed_d;
  logic                  err_q, err_d;
  logic                  last_q, last_d;
  logic                  m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]     m_addr_q, m_addr_d;
  logic [DATA_W-1:0]     m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0]     m_wstrb_q, m_wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [AXI_ID_W-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [AXI_ID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;

  logic                  aw_hs, ar_hs, w_hs, r_hs, b_hs, nat_done, r_more;
  logic [ADDR_W-1:0]     addr_inc;

  function automatic logic bad_burst(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] | (size != SIZE_OK);
  endfunction

  // Address channels only open in IDLE; writes take priority over reads.
  assign s_awready = (state_q == IDLE) & ~rst;
  assign s_arready = (state_q == IDLE) & ~rst & ~s_awvalid;
  assign s_wready  = (state_q == WR_DATA) & ~m_valid_q;

  assign aw_hs    = s_awvalid & s_awready;
  assign ar_hs    = s_arvalid & s_arready;
  assign w_hs     = s_wvalid & s_wready;
  assign r_hs     = rvalid_q & s_rready;
  assign b_hs     = bvalid_q & s_bready;
  assign nat_done = m_valid_q & m_ready;
  assign addr_inc = fixed_q ? addr_q : addr_q + STEP;
  // A new read beat may start once the R register is free or being drained mid-burst.
  assign r_more   = ~rvalid_q | (s_rready & ~rlast_q);

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through this block infers a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    fixed_d   = fixed_q;
    err_d     = err_q;
    last_d    = last_q;
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;

    if (nat_done) m_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (aw_hs) begin
          state_d = WR_DATA;
          addr_d  = s_awaddr;
          cnt_d   = s_awlen;
          fixed_d = (s_awburst == BURST_FIXED);
          err_d   = bad_burst(s_awburst, s_awsize);
          bid_d   = s_awid;
          last_d  = 1'b0;
        end else if (ar_hs) begin
          state_d = RD_DATA;
          cnt_d   = s_arlen;
          fixed_d = (s_arburst == BURST_FIXED);
          err_d   = bad_burst(s_arburst, s_arsize);
          rid_d   = s_arid;
          addr_d  = s_araddr;
          if (!bad_burst(s_arburst, s_arsize)) begin
            m_valid_d = 1'b1;
            m_addr_d  = s_araddr;
            m_wdata_d = '0;
            m_wstrb_d = '0;
            addr_d    = (s_arburst == BURST_FIXED) ? s_araddr : s_araddr + STEP;
          end
        end
      end

      WR_DATA: begin
        if (w_hs) begin
          if (s_wlast != (cnt_q == '0)) err_d = 1'b1;
          if (!err_q && |s_wstrb) begin
            m_valid_d = 1'b1;
            m_addr_d  = addr_q;
            m_wdata_d = s_wdata;
            m_wstrb_d = s_wstrb;
          end
          if (cnt_q == '0) begin
            if (!err_q && |s_wstrb) begin
              last_d = 1'b1;
            end else begin
              state_d  = WR_RESP;
              bvalid_d = 1'b1;
              bresp_d  = err_d ? RESP_SLVERR : RESP_OKAY;
            end
          end else begin
            cnt_d  = cnt_q - AXI_LEN_W'(1);
            addr_d = addr_inc;
          end
        end
        // Last beat went out natively: respond once the slave has taken it.
        if (nat_done && last_q) begin
          state_d  = WR_RESP;
          last_d   = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
        end
      end

      WR_RESP: begin
        if (b_hs) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
          err_d    = 1'b0;
        end
      end

      RD_DATA: begin
        if (r_hs) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            state_d = IDLE;
            err_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - AXI_LEN_W'(1);
          end
        end
        if (err_q) begin
          if (r_more) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            rlast_d  = (cnt_d == '0);
          end
        end else if (nat_done) begin
          rvalid_d = 1'b1;
          rdata_d  = m_rdata;
          rresp_d  = RESP_OKAY;
          rlast_d  = (cnt_q == '0);
        end else if (!m_valid_q && r_more) begin
          m_valid_d = 1'b1;
          m_addr_d  = addr_q;
          m_wdata_d = '0;
          m_wstrb_d = '0;
          addr_d    = addr_inc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      fixed_q   <= fixed_d;
      err_q     <= err_d;
      last_q    <= last_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_wstrb  = m_wstrb_q;
  assign s_bvalid = bvalid_q;
  assign s_bid    = bid_q;
  assign s_bresp  = bresp_q;
  assign s_rvalid = rvalid_q;
  assign s_rid    = rid_q;
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;
  assign s_rlast  = rlast_q;

endmodule

// File: tb/tb_axi2iob.sv
// Scoreboard bench for axi2iob: expected native accesses and B/R responses are
// queued as stimulus is driven and compared against what the monitors capture.
module tb_axi2iob;

  localparam int BUDGET = 300;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } nat_t;
  typedef struct packed { logic id; logic [31:0] data; logic [1:0] resp; logic last; } r_t;
  typedef struct packed { logic id; logic [1:0] resp; } b_t;
  typedef struct { nat_t t; int cyc; int vlen; } nat_obs_t;
  typedef struct { r_t t; int cyc; } r_obs_t;
  typedef struct { b_t t; int cyc; } b_obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  s_awid, s_arid, s_bid, s_rid;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata, m_addr, m_wdata, m_rdata;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic [3:0]  s_wstrb, m_wstrb;
  logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, m_valid, m_ready;

  axi2iob dut (
    .clk(clk), .rst(rst),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, aw_cyc = -1, ar_cyc = -1, w_cyc = -1;
  int wcnt = 0, stab_err = 0, ovl_err = 0, n_wait = 0;
  bit pend = 1'b0, rr_rand = 1'b0;
  logic [67:0] held;

  nat_t     exp_nat[$];
  r_t       exp_r[$];
  b_t       exp_b[$];
  nat_obs_t obs_nat[$];
  r_obs_t   obs_r[$];
  b_obs_t   obs_b[$];

  // Native slave: completes after n_wait wait cycles and returns the address as read data.
  always @(negedge clk) begin
    m_ready = m_valid && (wcnt == n_wait);
    m_rdata = m_addr;
    s_rready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitors: capture every handshake with its cycle stamp.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      wcnt <= 0;
      pend <= 1'b0;
    end else begin
      if (s_awvalid && s_awready) aw_cyc <= cyc;
      if (s_arvalid && s_arready) ar_cyc <= cyc;
      if (s_wvalid && s_wready) w_cyc <= cyc;
      if (s_bvalid && s_bready) obs_b.push_back('{t: b_t'{s_bid, s_bresp}, cyc: cyc});
      if (s_rvalid && s_rready)
        obs_r.push_back('{t: r_t'{s_rid, s_rdata, s_rresp, s_rlast}, cyc: cyc});
      if (m_valid && s_rvalid) ovl_err <= ovl_err + 1;
      if (m_valid && pend && {m_addr, m_wdata, m_wstrb} != held) stab_err <= stab_err + 1;
      pend <= m_valid && !m_ready;
      held <= {m_addr, m_wdata, m_wstrb};
      if (m_valid && m_ready) begin
        obs_nat.push_back('{t: nat_t'{m_addr, m_wdata, m_wstrb}, cyc: cyc, vlen: wcnt + 1});
        wcnt <= 0;
      end else if (m_valid) begin
        wcnt <= wcnt + 1;
      end
    end
  end

  function automatic logic [31:0] ready_valid_vec();
    return {26'd0, s_awready, s_arready, s_wready, s_bvalid, s_rvalid, m_valid};
  endfunction

  function automatic logic [139:0] payload_vec();
    return {m_addr, m_wdata, m_wstrb, s_rdata, s_bresp, s_rresp, s_bid, s_rid, s_rlast, 25'd0};
  endfunction

  task automatic aw_send(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1'b1;
    #1;
    while (!s_awready) begin
      if (t == BUDGET) begin n_cmp++; n_err++; $display("FAIL aw_timeout: awready 0, need 1"); break; end
      @(negedge clk); #1; t++;
    end
    @(negedge clk);
    s_awvalid = 1'b0;
  endtask

  task automatic ar_wait();
    int t = 0;
    #1;
    while (!s_arready) begin
      if (t == BUDGET) begin n_cmp++; n_err++; $display("FAIL ar_timeout: arready 0, need 1"); break; end
      @(negedge clk); #1; t++;
    end
    @(negedge clk);
    s_arvalid = 1'b0;
  endtask

  task automatic ar_send(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1;
    ar_wait();
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int t = 0;
    s_wdata = data; s_wstrb = strb; s_wlast = last; s_wvalid = 1'b1;
    #1;
    while (!s_wready) begin
      if (t == BUDGET) begin n_cmp++; n_err++; $display("FAIL w_timeout: wready 0, need 1"); break; end
      @(negedge clk); #1; t++;
    end
    @(negedge clk);
    s_wvalid = 1'b0;
  endtask

  task automatic wait_b(input int n);
    int t = 0;
    while (obs_b.size() < n) begin
      if (t == BUDGET) begin n_cmp++; n_err++; $display("FAIL b_timeout: got %0d, need %0d", obs_b.size(), n); break; end
      @(negedge clk); t++;
    end
  endtask

  task automatic wait_r(input int n);
    int t = 0;
    while (obs_r.size() < n) begin
      if (t == BUDGET) begin n_cmp++; n_err++; $display("FAIL r_timeout: got %0d, need %0d", obs_r.size(), n); break; end
      @(negedge clk); t++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (ready_valid_vec() !== 32'd0) begin n_err++; $display("FAIL rst_handshake: got %h, need 0", ready_valid_vec()); end
    n_cmp++; if (payload_vec() !== 140'd0) begin n_err++; $display("FAIL rst_payload: got %h, need 0", payload_vec()); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if ({s_awready, s_arready, s_wready} !== 3'b110) begin n_err++; $display("FAIL idle_ready: got %b, need 110", {s_awready, s_arready, s_wready}); end
    @(negedge clk);
  endtask

  task automatic test_single_write();
    nat_obs_t o; b_obs_t bo; nat_t e; b_t eb;
    exp_nat.push_back('{32'h100, 32'hDEADBEEF, 4'hF});
    exp_b.push_back('{1'b1, 2'b00});
    aw_send(1'b1, 32'h100, 8'd0, 3'd2, 2'b01);
    w_send(32'hDEADBEEF, 4'hF, 1'b1);
    wait_b(1);
    e = exp_nat.pop_front(); eb = exp_b.pop_front();
    n_cmp++;
    if (obs_nat.size() != 1) begin n_err++; $display("FAIL wr_nat_count: got %0d, need 1", obs_nat.size()); end
    else begin
      o = obs_nat.pop_front();
      n_cmp++; if (o.t !== e) begin n_err++; $display("FAIL wr_nat: got %h, need %h", o.t, e); end
      n_cmp++; if (o.cyc - w_cyc !== 1) begin n_err++; $display("FAIL wr_nat_lat: got %0d, need 1", o.cyc - w_cyc); end
      n_cmp++; if (w_cyc - aw_cyc !== 1) begin n_err++; $display("FAIL wr_w_lat: got %0d, need 1", w_cyc - aw_cyc); end
      if (obs_b.size() > 0) begin
        bo = obs_b.pop_front();
        n_cmp++; if (bo.t !== eb) begin n_err++; $display("FAIL wr_b: got %h, need %h", bo.t, eb); end
        n_cmp++; if (bo.cyc - o.cyc !== 1) begin n_err++; $display("FAIL wr_b_lat: got %0d, need 1", bo.cyc - o.cyc); end
      end
    end
  endtask

  task automatic test_incr_read(input logic [31:0] base, input bit rnd);
    r_obs_t o; r_t e; int first_cyc = 0;
    obs_nat.delete();
    ovl_err = 0;
    rr_rand = rnd;
    for (int i = 0; i < 4; i++) exp_r.push_back('{1'b0, base + 32'(4 * i), 2'b00, i == 3});
    ar_send(1'b0, base, 8'd3, 3'd2, 2'b01);
    wait_r(4);
    for (int i = 0; i < 4; i++) begin
      e = exp_r.pop_front();
      n_cmp++;
      if (obs_r.size() == 0) begin n_err++; $display("FAIL rd_beat%0d: got none, need %h", i, e); end
      else begin
        o = obs_r.pop_front();
        if (i == 0) first_cyc = o.cyc;
        if (o.t !== e) begin n_err++; $display("FAIL rd_beat%0d: got %h, need %h", i, o.t, e); end
      end
    end
    if (!rnd) begin
      n_cmp++; if (first_cyc - ar_cyc !== 2) begin n_err++; $display("FAIL rd_lat: got %0d, need 2", first_cyc - ar_cyc); end
      n_cmp++; if (o.cyc - first_cyc !== 6) begin n_err++; $display("FAIL rd_rate: got %0d, need 6", o.cyc - first_cyc); end
    end
    n_cmp++; if (obs_nat.size() != 4) begin n_err++; $display("FAIL rd_nat_count: got %0d, need 4", obs_nat.size()); end
    n_cmp++; if (ovl_err != 0) begin n_err++; $display("FAIL rd_overlap: got %0d, need 0", ovl_err); end
    rr_rand = 1'b0;
    obs_nat.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fixed_write();
    nat_obs_t o; b_obs_t bo; nat_t e; b_t eb;
    exp_nat.push_back('{32'h40, 32'h11111111, 4'hF});
    exp_nat.push_back('{32'h40, 32'h33333333, 4'h3});
    exp_b.push_back('{1'b0, 2'b00});
    aw_send(1'b0, 32'h40, 8'd2, 3'd2, 2'b00);
    w_send(32'h11111111, 4'hF, 1'b0);
    w_send(32'h22222222, 4'h0, 1'b0);
    w_send(32'h33333333, 4'h3, 1'b1);
    wait_b(1);
    n_cmp++; if (obs_nat.size() != 2) begin n_err++; $display("FAIL fx_nat_count: got %0d, need 2", obs_nat.size()); end
    while (exp_nat.size() > 0 && obs_nat.size() > 0) begin
      e = exp_nat.pop_front(); o = obs_nat.pop_front();
      n_cmp++; if (o.t !== e) begin n_err++; $display("FAIL fx_nat: got %h, need %h", o.t, e); end
    end
    exp_nat.delete(); obs_nat.delete();
    eb = exp_b.pop_front();
    if (obs_b.size() > 0) begin
      bo = obs_b.pop_front();
      n_cmp++; if (bo.t !== eb) begin n_err++; $display("FAIL fx_b: got %h, need %h", bo.t, eb); end
    end
  endtask

  task automatic test_err_write();
    b_obs_t bo; b_t eb;
    exp_b.push_back('{1'b1, 2'b10});
    aw_send(1'b1, 32'h80, 8'd1, 3'd2, 2'b10);
    w_send(32'hAAAA0000, 4'hF, 1'b0);
    w_send(32'hAAAA0001, 4'hF, 1'b1);
    wait_b(1);
    n_cmp++; if (obs_nat.size() != 0) begin n_err++; $display("FAIL ew_nat_count: got %0d, need 0", obs_nat.size()); end
    eb = exp_b.pop_front();
    if (obs_b.size() > 0) begin
      bo = obs_b.pop_front();
      n_cmp++; if (bo.t !== eb) begin n_err++; $display("FAIL ew_b: got %h, need %h", bo.t, eb); end
    end
    obs_nat.delete();
  endtask

  task automatic test_err_read();
    r_obs_t o; r_t e;
    exp_r.push_back('{1'b1, 32'd0, 2'b10, 1'b0});
    exp_r.push_back('{1'b1, 32'd0, 2'b10, 1'b1});
    ar_send(1'b1, 32'h300, 8'd1, 3'd0, 2'b01);
    wait_r(2);
    while (exp_r.size() > 0) begin
      e = exp_r.pop_front();
      n_cmp++;
      if (obs_r.size() == 0) begin n_err++; $display("FAIL er_beat: got none, need %h", e); end
      else begin
        o = obs_r.pop_front();
        if (o.t !== e) begin n_err++; $display("FAIL er_beat: got %h, need %h", o.t, e); end
      end
    end
    n_cmp++; if (obs_nat.size() != 0) begin n_err++; $display("FAIL er_nat_count: got %0d, need 0", obs_nat.size()); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_arbitration();
    b_obs_t bo; r_obs_t o; r_t e;
    obs_nat.delete();
    e = '{1'b0, 32'h20, 2'b00, 1'b1};
    s_arid = 1'b0; s_araddr = 32'h20; s_arlen = 8'd0; s_arsize = 3'd2; s_arburst = 2'b01;
    s_arvalid = 1'b1;
    aw_send(1'b1, 32'h10, 8'd0, 3'd2, 2'b01);
    w_send(32'h00001234, 4'hF, 1'b1);
    wait_b(1);
    ar_wait();
    wait_r(1);
    n_cmp++;
    if (obs_b.size() == 0) begin n_err++; $display("FAIL arb_b: got none, need one"); end
    else begin
      bo = obs_b.pop_front();
      if (ar_cyc <= bo.cyc) begin n_err++; $display("FAIL arb_order: ar cycle %0d, need after b cycle %0d", ar_cyc, bo.cyc); end
    end
    if (obs_r.size() > 0) begin
      o = obs_r.pop_front();
      n_cmp++; if (o.t !== e) begin n_err++; $display("FAIL arb_r: got %h, need %h", o.t, e); end
    end
    obs_nat.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wait_states();
    nat_obs_t o; r_obs_t ro; nat_t e;
    n_wait = 3;
    stab_err = 0;
    e = '{32'h44, 32'hA5A5A5A5, 4'hF};
    aw_send(1'b0, 32'h44, 8'd0, 3'd2, 2'b01);
    w_send(32'hA5A5A5A5, 4'hF, 1'b1);
    wait_b(1);
    obs_b.delete();
    ar_send(1'b0, 32'h48, 8'd0, 3'd2, 2'b01);
    wait_r(1);
    n_cmp++;
    if (obs_nat.size() != 2) begin n_err++; $display("FAIL ws_nat_count: got %0d, need 2", obs_nat.size()); end
    else begin
      o = obs_nat.pop_front();
      if (o.t !== e) begin n_err++; $display("FAIL ws_nat: got %h, need %h", o.t, e); end
      n_cmp++; if (o.vlen !== 4) begin n_err++; $display("FAIL ws_wr_hold: got %0d, need 4", o.vlen); end
      o = obs_nat.pop_front();
      n_cmp++; if (o.vlen !== 4) begin n_err++; $display("FAIL ws_rd_hold: got %0d, need 4", o.vlen); end
    end
    if (obs_r.size() > 0) begin
      ro = obs_r.pop_front();
      n_cmp++; if (ro.t.data !== 32'h48) begin n_err++; $display("FAIL ws_rdata: got %h, need 00000048", ro.t.data); end
    end
    n_cmp++; if (stab_err != 0) begin n_err++; $display("FAIL ws_stable: got %0d changes, need 0", stab_err); end
    n_wait = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    r_obs_t o; r_t e;
    ar_send(1'b0, 32'h500, 8'd7, 3'd2, 2'b01);
    wait_r(1);
    obs_r.delete(); obs_nat.delete();
    rst = 1'b1;
    #1;
    n_cmp++; if (ready_valid_vec() !== 32'd0) begin n_err++; $display("FAIL mid_rst_handshake: got %h, need 0", ready_valid_vec()); end
    n_cmp++; if (payload_vec() !== 140'd0) begin n_err++; $display("FAIL mid_rst_payload: got %h, need 0", payload_vec()); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (obs_r.size() != 0) begin n_err++; $display("FAIL mid_rst_stray: got %0d beats, need 0", obs_r.size()); end
    e = '{1'b1, 32'h600, 2'b00, 1'b1};
    ar_send(1'b1, 32'h600, 8'd0, 3'd2, 2'b01);
    wait_r(1);
    if (obs_r.size() > 0) begin
      o = obs_r.pop_front();
      n_cmp++; if (o.t !== e) begin n_err++; $display("FAIL post_rst_read: got %h, need %h", o.t, e); end
    end
  endtask

  initial begin
    rst = 1'b1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_bready = 1'b1; s_rready = 1'b1;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0;
    m_ready = 1'b0; m_rdata = '0;
    test_reset();
    test_single_write();
    test_incr_read(32'h200, 1'b0);
    test_incr_read(32'h200, 1'b1);
    test_fixed_write();
    test_err_write();
    test_err_read();
    test_arbitration();
    test_wait_states();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
